// File: rtl/viterbi_pkg.sv
// Shared Viterbi datapath definitions: default metric widths, the path-metric
// ceiling and the metric types used by the ACS stages.
package viterbi_pkg;

  localparam int BM_W = 2;
  localparam int PM_W = 2;

  localparam logic [PM_W-1:0] PM_MAX = {PM_W{1'b1}};

  typedef logic [BM_W-1:0] bm_t;
  typedef logic [PM_W-1:0] pm_t;

endpackage : viterbi_pkg

// File: rtl/add_unit_if.sv
// Operand/result bundle of the ACS saturating add stage; the slave side is the
// add unit, the master side is whatever feeds metrics and consumes results.
interface add_unit_if #(
  parameter int W_BM = viterbi_pkg::BM_W,
  parameter int W_PM = viterbi_pkg::PM_W
);

  logic [W_BM-1:0] i_BM;
  logic [W_PM-1:0] i_PM;
  logic            i_valid;
  logic [W_PM-1:0] o_PM;
  logic            o_sat;
  logic [W_PM-1:0] o_PM_r;
  logic            o_sat_r;
  logic            o_valid;

  modport master (
    output i_BM, i_PM, i_valid,
    input  o_PM, o_sat, o_PM_r, o_sat_r, o_valid
  );

  modport slave (
    input  i_BM, i_PM, i_valid,
    output o_PM, o_sat, o_PM_r, o_sat_r, o_valid
  );

endinterface : add_unit_if

// File: rtl/add_unit_sat_adder.sv
// Pure combinational zero-extend, add and clamp of a branch metric onto a path
// metric; the result never wraps past the path-metric ceiling.
module sat_adder #(
  parameter int W_BM = 2,
  parameter int W_PM = 2
) (
  input  logic [W_BM-1:0] bm_i,
  input  logic [W_PM-1:0] pm_i,
  output logic [W_PM-1:0] sum_o,
  output logic            sat_o
);

  logic [W_PM:0] sum_ext;

  // Both operands are at most 2^W_PM-1, so the extra bit is set exactly when
  // the true sum exceeds the ceiling; a sum equal to the ceiling is not saturated.
  assign sum_ext = {{(W_PM + 1 - W_BM){1'b0}}, bm_i} + {1'b0, pm_i};
  assign sat_o   = sum_ext[W_PM];
  assign sum_o   = sat_o ? {W_PM{1'b1}} : sum_ext[W_PM-1:0];

endmodule : sat_adder

// File: rtl/add_unit.sv
// Saturating add stage of the ACS datapath: combinational result for same-cycle
// use plus a one-cycle registered copy qualified by a valid flag.
module add_unit
  import viterbi_pkg::*;
#(
  parameter int W_BM = BM_W,
  parameter int W_PM = PM_W
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  add_unit_if.slave  bus
);

  logic [W_PM-1:0] pm_d, pm_q;
  logic            sat_d, sat_q;
  logic            valid_q;

  sat_adder #(
    .W_BM (W_BM),
    .W_PM (W_PM)
  ) u_sat_adder (
    .bm_i  (bus.i_BM),
    .pm_i  (bus.i_PM),
    .sum_o (pm_d),
    .sat_o (sat_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pm_q    <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.i_valid;
      if (bus.i_valid) begin
        pm_q  <= pm_d;
        sat_q <= sat_d;
      end
    end
  end

  assign bus.o_PM    = pm_d;
  assign bus.o_sat   = sat_d;
  assign bus.o_PM_r  = pm_q;
  assign bus.o_sat_r = sat_q;
  assign bus.o_valid = valid_q;

endmodule : add_unit

// File: tb/tb_add_unit.sv
// Self-checking bench for add_unit: combinational sweep, saturation edges,
// pipeline hold behaviour, asynchronous reset and a scoreboarded random run.
module tb_add_unit;
  import viterbi_pkg::*;

  typedef struct packed {
    logic [1:0] pm;
    logic       sat;
    logic       valid;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  exp_t sb[$];
  logic [1:0] m_pm;
  logic       m_sat;

  add_unit_if #(.W_BM(2), .W_PM(2)) bus ();

  add_unit #(.W_BM(2), .W_PM(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] ref_pm(input int a, input int b);
    return (a + b > 3) ? 2'd3 : 2'(a + b);
  endfunction

  function automatic logic ref_sat(input int a, input int b);
    return (a + b) > 3;
  endfunction

  task automatic test_reset();
    bus.i_BM = 2'd2; bus.i_PM = 2'd1; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({bus.o_PM_r, bus.o_sat_r, bus.o_valid} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_regs got pm_r=%0d sat_r=%0d valid=%0d exp 0/0/0",
               bus.o_PM_r, bus.o_sat_r, bus.o_valid);
    end
    tests_run++;
    if (bus.o_PM !== 2'd3 || bus.o_sat !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_comb got pm=%0d sat=%0d exp 3/0", bus.o_PM, bus.o_sat);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst_n = 1'b1;
    m_pm = 2'd0; m_sat = 1'b0;
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        bus.i_BM = 2'(a); bus.i_PM = 2'(b);
        #1;
        tests_run++;
        if (bus.o_PM !== ref_pm(a, b)) begin
          tests_failed++;
          $display("FAIL sweep_pm %0d+%0d got %0d exp %0d", a, b, bus.o_PM, ref_pm(a, b));
        end
        tests_run++;
        if (bus.o_sat !== ref_sat(a, b)) begin
          tests_failed++;
          $display("FAIL sweep_sat %0d+%0d got %0d exp %0d", a, b, bus.o_sat, ref_sat(a, b));
        end
      end
    end
  endtask

  task automatic test_sat_flag();
    logic [5:0] vec [3];
    vec[0] = {2'd2, 2'd1, 2'd3}; // bm, pm, expected result
    vec[1] = {2'd2, 2'd2, 2'd3};
    vec[2] = {2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 3; i++) begin
      logic exp_sat;
      exp_sat = (i != 0);
      bus.i_BM = vec[i][5:4]; bus.i_PM = vec[i][3:2];
      #1;
      tests_run++;
      if (bus.o_PM !== vec[i][1:0] || bus.o_sat !== exp_sat) begin
        tests_failed++;
        $display("FAIL sat_flag %0d+%0d got pm=%0d sat=%0d exp pm=%0d sat=%0d",
                 vec[i][5:4], vec[i][3:2], bus.o_PM, bus.o_sat, vec[i][1:0], exp_sat);
      end
    end
  endtask

  // One scoreboarded cycle: drive at negedge, push the model's registered
  // expectation, then pop and compare just after the capturing edge.
  task automatic test_pipeline();
    int a_s [2];
    int b_s [2];
    logic v_s [2];
    exp_t e;
    a_s[0] = 1; b_s[0] = 1; v_s[0] = 1'b1;
    a_s[1] = 3; b_s[1] = 3; v_s[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.i_BM = 2'(a_s[i]); bus.i_PM = 2'(b_s[i]); bus.i_valid = v_s[i];
      if (v_s[i]) begin
        m_pm = ref_pm(a_s[i], b_s[i]); m_sat = ref_sat(a_s[i], b_s[i]);
      end
      sb.push_back('{pm: m_pm, sat: m_sat, valid: v_s[i]});
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if (bus.o_PM_r !== e.pm || bus.o_sat_r !== e.sat || bus.o_valid !== e.valid) begin
        tests_failed++;
        $display("FAIL pipeline_step%0d got pm_r=%0d sat_r=%0d valid=%0d exp %0d/%0d/%0d",
                 i, bus.o_PM_r, bus.o_sat_r, bus.o_valid, e.pm, e.sat, e.valid);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.i_BM = 2'd3; bus.i_PM = 2'd3; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (bus.o_PM_r !== 2'd3 || bus.o_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_pre got pm_r=%0d valid=%0d exp 3/1", bus.o_PM_r, bus.o_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.o_PM_r, bus.o_sat_r, bus.o_valid} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL areset_regs got pm_r=%0d sat_r=%0d valid=%0d exp 0/0/0",
               bus.o_PM_r, bus.o_sat_r, bus.o_valid);
    end
    tests_run++;
    if (bus.o_PM !== 2'd3 || bus.o_sat !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_comb got pm=%0d sat=%0d exp 3/1", bus.o_PM, bus.o_sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_pm = 2'd0; m_sat = 1'b0;
    bus.i_BM = 2'd1; bus.i_PM = 2'd2; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (bus.o_PM_r !== 2'd3 || bus.o_sat_r !== 1'b0 || bus.o_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_first_capture got pm_r=%0d sat_r=%0d valid=%0d exp 3/0/1",
               bus.o_PM_r, bus.o_sat_r, bus.o_valid);
    end
    m_pm = 2'd3; m_sat = 1'b0;
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      int a, b;
      logic v;
      a = int'($urandom_range(0, 3));
      b = int'($urandom_range(0, 3));
      v = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      bus.i_BM = 2'(a); bus.i_PM = 2'(b); bus.i_valid = v;
      #1;
      tests_run++;
      if (bus.o_PM !== ref_pm(a, b) || bus.o_sat !== ref_sat(a, b)) begin
        tests_failed++;
        $display("FAIL random_comb %0d+%0d got pm=%0d sat=%0d exp %0d/%0d",
                 a, b, bus.o_PM, bus.o_sat, ref_pm(a, b), ref_sat(a, b));
      end
      if (v) begin
        m_pm = ref_pm(a, b); m_sat = ref_sat(a, b);
      end
      sb.push_back('{pm: m_pm, sat: m_sat, valid: v});
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if (bus.o_PM_r !== e.pm || bus.o_sat_r !== e.sat || bus.o_valid !== e.valid) begin
        tests_failed++;
        $display("FAIL random_reg iter %0d got pm_r=%0d sat_r=%0d valid=%0d exp %0d/%0d/%0d",
                 i, bus.o_PM_r, bus.o_sat_r, bus.o_valid, e.pm, e.sat, e.valid);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.i_BM     = '0;
    bus.i_PM     = '0;
    bus.i_valid  = 1'b0;
    m_pm         = 2'd0;
    m_sat        = 1'b0;
    test_reset();
    test_sweep();
    test_sat_flag();
    test_pipeline();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_add_unit

// File: doc/add_unit.md
Name: add_unit

Overview:
- Saturating add stage of the Viterbi decoder's Add-Compare-Select (ACS) datapath.
- Adds a branch metric (BM) to a path metric (PM) and clamps the result at the maximum PM value, so metrics never wrap.
- Provides a combinational result for use inside the same ACS cycle.
- Provides a registered copy with a valid flag for pipelined ACS configurations.

Parameters:
- W_BM, 2, branch-metric width in bits; must satisfy W_BM <= W_PM.
- W_PM, 2, path-metric width in bits; the saturation ceiling is PM_MAX = 2^W_PM - 1.

Ports:
- i_clk  input  1  system clock; registered outputs update on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_BM  input  W_BM  branch metric, unsigned.
- i_PM  input  W_PM  incoming path metric, unsigned.
- i_valid  input  1  qualifies i_BM/i_PM for the registered path.
- o_PM  output  W_PM  combinational saturated sum.
- o_sat  output  1  combinational flag: high when the true sum exceeds PM_MAX.
- o_PM_r  output  W_PM  registered saturated sum.
- o_sat_r  output  1  registered o_sat.
- o_valid  output  1  registered i_valid.

Behaviour:
- Arithmetic:
  - sum = zero_extend(i_BM) + zero_extend(i_PM), computed at W_PM+1 bits; no overflow is possible at that width.
  - o_PM = PM_MAX when sum >= PM_MAX, else sum[W_PM-1:0]. In effect o_PM = min(sum, PM_MAX).
  - o_sat = 1 only when sum > PM_MAX. sum == PM_MAX is exact, not saturated, so o_sat = 0.
- All values are unsigned; there is no sign handling.
- Combinational path:
  - Zero latency; o_PM and o_sat follow the inputs with no clock involved.
  - Outputs are valid regardless of i_valid and regardless of reset.
- Registered path:
  - On each rising i_clk with i_rst_n high: o_valid <= i_valid.
  - When i_valid = 1: o_PM_r <= o_PM and o_sat_r <= o_sat.
  - When i_valid = 0: o_PM_r and o_sat_r hold their previous values.
  - Latency is exactly 1 cycle.
- Reset:
  - i_rst_n low clears o_PM_r, o_sat_r and o_valid to 0 immediately, without waiting for a clock edge.
  - Reset may be asserted mid-stream; any in-flight result is discarded.
  - After release, the first capture happens at the first rising edge with i_rst_n high.
- X-handling: outputs must be fully 2-state for 2-state inputs. The bench uses case-equality compares.
- Boundary values (W=2):
  - 0+0 gives 0 with no saturation.
  - 3+0 and 0+3 give 3 with o_sat = 0.
  - 2+1 gives 3 with o_sat = 0.
  - 2+2 gives 3 with o_sat = 1.
  - 3+3 gives 3 with o_sat = 1.

Decomposition:
- Shared package viterbi_pkg holds:
  - default localparams BM_W = 2 and PM_W = 2;
  - PM_MAX derived from PM_W;
  - typedefs bm_t and pm_t.
- One natural sub-module: sat_adder. It contains the pure combinational zero-extend, add and clamp, and produces sum and sat.
- add_unit instantiates sat_adder and adds the output register stage.

Test Plan:
- Exhaustive sweep of i_BM and i_PM over 0..3 each (16 cases):
  - o_PM must equal min(i_BM + i_PM, 3) in every case;
  - e.g. 1+1 -> 2, 1+2 -> 3, 3+2 -> 3.
- Saturation flag check:
  - 2+1 -> o_PM = 3, o_sat = 0;
  - 2+2 -> o_PM = 3, o_sat = 1;
  - 3+3 -> o_PM = 3, o_sat = 1.
- Pipeline check:
  - drive i_valid = 1 with 1+1, then i_valid = 0 with 3+3;
  - -> o_PM_r = 2, o_valid = 1 after edge 1;
  - -> o_PM_r still 2, o_valid = 0 after edge 2.
- Asynchronous reset:
  - with o_PM_r = 3 and o_valid = 1, pull i_rst_n low between clock edges;
  - -> all registered outputs are 0 immediately;
  - -> combinational o_PM still shows the current sum.
- Random regression:
  - 34 or more random input pairs;
  - combinational and registered outputs are compared against the min(sum, 3) model;
  - zero mismatches required.
